// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: load/store funct3 codes, ResultSrc encodings,
// memory-stage FSM states and the access alignment check.
package riscv_pkg;

  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;
  localparam logic [2:0] Funct3Sb  = 3'b000;
  localparam logic [2:0] Funct3Sh  = 3'b001;
  localparam logic [2:0] Funct3Sw  = 3'b010;

  typedef enum logic [1:0] {
    ResAlu = 2'b00,
    ResMem = 2'b01,
    ResPc4 = 2'b10,
    ResImm = 2'b11
  } result_src_e;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } mem_state_e;

  // Unused funct3 codes (including LBU/LHU codes on a store) count as misaligned.
  function automatic logic is_misaligned(input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] offset);
    logic mis;
    case (funct3)
      3'b000:  mis = 1'b0;
      3'b001:  mis = offset[0];
      3'b010:  mis = |offset;
      3'b100,
      3'b101:  mis = is_store;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-enabled data RAM: synchronous write, combinational read. A read in the
// same cycle as a write to that word returns the old contents.
// Contents are never reset.
module data_mem #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] r_mem [DEPTH];

  // Write only the enabled byte lanes.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = r_mem[addr];

endmodule

// File: rtl/mem_stage_wb.sv
// RV32I memory stage with MEM/WB pipeline register. Performs aligned byte,
// half and word accesses to an internal RAM with LATENCY extra wait cycles,
// stalling upstream until the access completes. Stall cycles put a bubble
// into the W registers.
module mem_stage_wb
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [31:0] ExtImmM,
  input  logic [2:0]  Funct3M,
  output logic        MemStall,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ExtImmW,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic        MisalignW
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [2:0]  LatCnt = 3'(LATENCY);

  mem_state_e      r_state;
  logic [2:0]      r_cnt;

  logic            w_is_load;
  logic            w_access;
  logic            w_complete;
  logic            w_done;
  logic            w_misalign;
  logic [AW-1:0]   w_index;
  logic [1:0]      w_off;
  logic [31:0]     w_rdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_load_data;
  logic            w_we;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;

  assign w_is_load  = (ResultSrcM == ResMem);
  assign w_access   = MemWriteM | w_is_load;
  assign w_index    = ALUResultM[AW+1:2];
  assign w_off      = ALUResultM[1:0];
  assign w_misalign = w_access & is_misaligned(MemWriteM, Funct3M, w_off);

  // Access completes in its first cycle when LATENCY is 0, otherwise when
  // the wait counter reaches LATENCY.
  always_comb begin
    w_complete = 1'b1;
    if (LATENCY != 0) begin
      w_complete = (r_state == StWait) && (r_cnt == LatCnt);
    end
  end

  // W registers advance on non-access instructions and on access completion.
  assign w_done   = ~w_access | w_complete;
  assign MemStall = w_access & ~w_complete & ~rst;

  // Wait-state sequencer: counts cycles of the access currently presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_access && (LATENCY != 0)) begin
            r_state <= StWait;
            r_cnt   <= 3'd1;
          end
        end
        StWait: begin
          // Dropping the access mid-wait also returns to idle.
          if (!w_access || w_complete) begin
            r_state <= StIdle;
            r_cnt   <= 3'd0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  // Store lane steering and byte enables.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'h0;
    case (Funct3M)
      Funct3Sb: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{WriteDataM[7:0]}};
      end
      Funct3Sh: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteDataM[15:0]}};
      end
      Funct3Sw: begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
      end
      default: ;
    endcase
  end

  // Commit once, at the completion edge, and never under reset.
  assign w_we = MemWriteM & w_complete & ~w_misalign & ~rst;

  data_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (w_we),
    .be   (w_be),
    .addr (w_index),
    .wdata(w_wdata),
    .rdata(w_rdata)
  );

  // Load lane selection and sign/zero extension.
  always_comb begin
    w_byte      = w_rdata[{w_off, 3'b000} +: 8];
    w_half      = w_off[1] ? w_rdata[31:16] : w_rdata[15:0];
    w_load_data = 32'h0;
    case (Funct3M)
      Funct3Lb:  w_load_data = {{24{w_byte[7]}}, w_byte};
      Funct3Lh:  w_load_data = {{16{w_half[15]}}, w_half};
      Funct3Lw:  w_load_data = w_rdata;
      Funct3Lbu: w_load_data = {24'h0, w_byte};
      Funct3Lhu: w_load_data = {16'h0, w_half};
      default:   w_load_data = 32'h0;
    endcase
    if (w_misalign) begin
      w_load_data = 32'h0;
    end
  end

  // MEM/WB register: load the M fields on completion, a bubble otherwise.
  always_ff @(posedge clk) begin
    if (rst || !w_done) begin
      ALUResultW <= 32'h0;
      ReadDataW  <= 32'h0;
      PCPlus4W   <= 32'h0;
      ExtImmW    <= 32'h0;
      RdW        <= 5'd0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      MisalignW  <= 1'b0;
    end else begin
      ALUResultW <= ALUResultM;
      ReadDataW  <= w_is_load ? w_load_data : 32'h0;
      PCPlus4W   <= PCPlus4M;
      ExtImmW    <= ExtImmM;
      RdW        <= RdM;
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      MisalignW  <= w_misalign;
    end
  end

endmodule

// File: tb/tb_mem_stage_wb.sv
// Scoreboard bench for mem_stage_wb: instance 0 with LATENCY=0, instance 1
// with LATENCY=3. The driver pushes expected W contents; the monitor pops and
// compares whenever a W update is due and checks for bubbles otherwise.
module tb_mem_stage_wb;
  import riscv_pkg::*;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  rs;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic [31:0] alu_m [2];
  logic [31:0] wd_m  [2];
  logic [31:0] pc4_m [2];
  logic [31:0] imm_m [2];
  logic [4:0]  rd_m  [2];
  logic        rw_m  [2];
  logic        mw_m  [2];
  logic [1:0]  rs_m  [2];
  logic [2:0]  f3_m  [2];
  logic        vld   [2];

  logic        ms    [2];
  logic [31:0] alu_w [2];
  logic [31:0] rdt_w [2];
  logic [31:0] pc4_w [2];
  logic [31:0] imm_w [2];
  logic [4:0]  rd_w  [2];
  logic        rw_w  [2];
  logic [1:0]  rs_w  [2];
  logic        mis_w [2];

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;
  logic [31:0] pc = 32'h0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_stage_wb #(
      .DEPTH  (1024),
      .LATENCY(g * 3)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .ALUResultM(alu_m[g]),
      .WriteDataM(wd_m[g]),
      .PCPlus4M  (pc4_m[g]),
      .RdM       (rd_m[g]),
      .RegWriteM (rw_m[g]),
      .MemWriteM (mw_m[g]),
      .ResultSrcM(rs_m[g]),
      .ExtImmM   (imm_m[g]),
      .Funct3M   (f3_m[g]),
      .MemStall  (ms[g]),
      .ALUResultW(alu_w[g]),
      .ReadDataW (rdt_w[g]),
      .PCPlus4W  (pc4_w[g]),
      .ExtImmW   (imm_w[g]),
      .RdW       (rd_w[g]),
      .RegWriteW (rw_w[g]),
      .ResultSrcW(rs_w[g]),
      .MisalignW (mis_w[g])
    );
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void chk_w(input string name, input exp_t a, input exp_t e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got alu=%h rdata=%h pc4=%h imm=%h rd=%0d rw=%b rs=%b mis=%b, expected alu=%h rdata=%h pc4=%h imm=%h rd=%0d rw=%b rs=%b mis=%b",
               name, a.alu, a.rdata, a.pc4, a.imm, a.rd, a.rw, a.rs, a.mis,
               e.alu, e.rdata, e.pc4, e.imm, e.rd, e.rw, e.rs, e.mis);
    end
  endfunction

  function automatic exp_t act_w(input int d);
    exp_t a;
    a.alu   = alu_w[d];
    a.rdata = rdt_w[d];
    a.pc4   = pc4_w[d];
    a.imm   = imm_w[d];
    a.rd    = rd_w[d];
    a.rw    = rw_w[d];
    a.rs    = rs_w[d];
    a.mis   = mis_w[d];
    return a;
  endfunction

  // Monitor: a cycle with a valid instruction, no stall and no reset must
  // be followed by that instruction in W; every other edge yields a bubble.
  initial begin
    logic pend [2];
    exp_t a;
    exp_t e;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int d = 0; d < 2; d++) begin
          a = act_w(d);
          if (pend[d]) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
              n_cmp++;
              n_fail++;
              $display("FAIL sb_empty_dut%0d: W update with no expected entry", d);
            end else begin
              if (d == 0) e = q0.pop_front();
              else        e = q1.pop_front();
              chk_w($sformatf("wb_dut%0d", d), a, e);
            end
          end else begin
            chk_w($sformatf("bubble_dut%0d", d), a, '0);
          end
          pend[d] = !rst[d] && vld[d] && !ms[d];
        end
      end
    end
  end

  task automatic nop(input int d);
    alu_m[d] = '0; wd_m[d] = '0; pc4_m[d] = '0; imm_m[d] = '0; rd_m[d] = '0;
    rw_m[d] = 1'b0; mw_m[d] = 1'b0; rs_m[d] = 2'b00; f3_m[d] = 3'b000; vld[d] = 1'b0;
  endtask

  task automatic drive(input int d, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [2:0] f3, input logic mw, input logic [1:0] rs,
                       input logic rw, input logic [4:0] rd, input logic [31:0] imm);
    alu_m[d] = alu; wd_m[d] = wd; pc4_m[d] = pc; imm_m[d] = imm; rd_m[d] = rd;
    rw_m[d] = rw; mw_m[d] = mw; rs_m[d] = rs; f3_m[d] = f3; vld[d] = 1'b1;
  endtask

  // Count stall cycles of the presented instruction, then step past its edge.
  task automatic wait_done(input int d, input int exp_stall, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (ms[d] && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_stall"}, 32'(n), 32'(exp_stall));
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int d, input logic [31:0] alu, input logic [31:0] wd,
                    input logic [2:0] f3, input logic mw, input logic [1:0] rs,
                    input logic rw, input logic [4:0] rd, input logic [31:0] imm,
                    input logic [31:0] exp_rdata, input logic exp_mis,
                    input int exp_stall, input string name);
    exp_t e;
    pc = pc + 32'd4;
    e = '{alu: alu, rdata: exp_rdata, pc4: pc, imm: imm, rd: rd, rw: rw, rs: rs,
          mis: exp_mis};
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    drive(d, alu, wd, f3, mw, rs, rw, rd, imm);
    wait_done(d, exp_stall, name);
  endtask

  task automatic st(input int d, input logic [31:0] addr, input logic [31:0] data,
                    input logic [2:0] f3, input logic rw, input logic mis);
    op(d, addr, data, f3, 1'b1, 2'b00, rw, rw ? 5'd9 : 5'd0, 32'h0, 32'h0, mis,
       (d == 1) ? 3 : 0, "st");
  endtask

  task automatic ld(input int d, input logic [31:0] addr, input logic [2:0] f3,
                    input logic [31:0] exp, input logic mis);
    op(d, addr, 32'h0, f3, 1'b0, 2'b01, 1'b1, 5'd5, 32'h0, exp, mis,
       (d == 1) ? 3 : 0, "ld");
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      nop(d);
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    // A store presented during reset must not stall.
    drive(1, 32'h40, 32'h0BAD_F00D, Funct3Sw, 1'b1, 2'b00, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("reset_stall_dut0", 32'(ms[0]), 32'h0);
    chk("reset_stall_dut1", 32'(ms[1]), 32'h0);
    @(posedge clk);
    #1;
    nop(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // LATENCY=0 instance.
    st(0, 32'h10, 32'hDEAD_BEEF, Funct3Sw, 1'b0, 1'b0);
    ld(0, 32'h10, Funct3Lw, 32'hDEAD_BEEF, 1'b0);
    st(0, 32'h10, 32'h8081_8283, Funct3Sw, 1'b0, 1'b0);
    ld(0, 32'h13, Funct3Lb,  32'hFFFF_FF80, 1'b0);
    ld(0, 32'h13, Funct3Lbu, 32'h0000_0080, 1'b0);
    ld(0, 32'h12, Funct3Lh,  32'hFFFF_8081, 1'b0);
    ld(0, 32'h10, Funct3Lhu, 32'h0000_8283, 1'b0);
    st(0, 32'h14, 32'h1122_3344, Funct3Sw, 1'b0, 1'b0);
    st(0, 32'h15, 32'h1234_56AA, Funct3Sb, 1'b0, 1'b0);
    ld(0, 32'h14, Funct3Lw, 32'h1122_AA44, 1'b0);
    ld(0, 32'h15, Funct3Lb, 32'hFFFF_FFAA, 1'b0);
    st(0, 32'h16, 32'hFFFF_BEEF, Funct3Sh, 1'b0, 1'b0);
    ld(0, 32'h14, Funct3Lw, 32'hBEEF_AA44, 1'b0);
    ld(0, 32'h16, Funct3Lh, 32'hFFFF_BEEF, 1'b0);
    // Misaligned and unused-code accesses.
    st(0, 32'h12, 32'h9999_9999, Funct3Sw, 1'b1, 1'b1);
    st(0, 32'h11, 32'h7777_7777, Funct3Sh, 1'b0, 1'b1);
    ld(0, 32'h10, Funct3Lw, 32'h8081_8283, 1'b0);
    ld(0, 32'h11, Funct3Lw, 32'h0, 1'b1);
    ld(0, 32'h13, Funct3Lh, 32'h0, 1'b1);
    ld(0, 32'h10, 3'b011,   32'h0, 1'b1);
    // Upper address bits are ignored.
    st(0, 32'h1000_0018, 32'hCAFE_F00D, Funct3Sw, 1'b0, 1'b0);
    ld(0, 32'h0000_0018, Funct3Lw, 32'hCAFE_F00D, 1'b0);
    st(0, 32'h0000_0FFC, 32'hA5A5_5A5A, Funct3Sw, 1'b0, 1'b0);
    ld(0, 32'h8000_7FFC, Funct3Lw, 32'hA5A5_5A5A, 1'b0);
    // Non-access instructions.
    op(0, 32'h0000_1234, 32'h0, 3'b000, 1'b0, 2'b00, 1'b1, 5'd7, 32'h0, 32'h0, 1'b0, 0, "alu");
    op(0, 32'h0000_0055, 32'h0, 3'b010, 1'b0, 2'b10, 1'b1, 5'd1, 32'h0, 32'h0, 1'b0, 0, "jal");
    op(0, 32'h0, 32'h0, 3'b000, 1'b0, 2'b11, 1'b1, 5'd31, 32'hABCD_E000, 32'h0, 1'b0, 0, "lui");
    nop(0);
    repeat (2) @(posedge clk);
    #1;

    // LATENCY=3 instance, back-to-back without idle gaps.
    st(1, 32'h40, 32'h1111_1111, Funct3Sw, 1'b0, 1'b0);
    ld(1, 32'h40, Funct3Lw, 32'h1111_1111, 1'b0);
    op(1, 32'h0000_0AAA, 32'h0, 3'b000, 1'b0, 2'b00, 1'b1, 5'd3, 32'h0, 32'h0, 1'b0, 0, "alu1");
    ld(1, 32'h41, Funct3Lbu, 32'h0000_0011, 1'b0);
    ld(1, 32'h40, Funct3Lw, 32'h1111_1111, 1'b0);
    st(1, 32'h40, 32'h2222_2222, Funct3Sw, 1'b0, 1'b0);
    ld(1, 32'h40, Funct3Lw, 32'h2222_2222, 1'b0);
    ld(1, 32'h43, Funct3Lh, 32'h0, 1'b1);

    // Reset in the second cycle of a pending store.
    pc = pc + 32'd4;
    e = '{alu: 32'h40, rdata: 32'h0, pc4: pc, imm: 32'h0, rd: 5'd0, rw: 1'b0, rs: 2'b00,
          mis: 1'b0};
    q1.push_back(e);
    drive(1, 32'h40, 32'h5566_7788, Funct3Sw, 1'b1, 2'b00, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("stall_pre_rst", 32'(ms[1]), 32'h1);
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    @(negedge clk);
    chk("stall_in_rst", 32'(ms[1]), 32'h0);
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    chk("store_dropped", g_dut[1].u_dut.u_mem.r_mem[16], 32'h2222_2222);
    wait_done(1, 3, "st_after_rst");
    ld(1, 32'h40, Funct3Lw, 32'h5566_7788, 1'b0);
    nop(1);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(q0.size() + q1.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
